// File: rtl/branch_encoder.sv
// rtl/branch_encoder.sv - 6502 branch encoder: (cond, pc, target) to branch machine-code bytes
//
// Purpose: turns a branch request into 6502 machine code and writes the bytes to program
// memory through a valid/ready byte port. A reachable target gives the 2-byte relative form.
// An unreachable target gives the 5-byte long form (inverted branch over a JMP abs) when
// LONG_FORM_EN=1. When LONG_FORM_EN=0 it raises err_range and writes nothing.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only while idle)
//   req_cond, req_pc, req_target   condition code, opcode address, branch destination
//   wr_valid/wr_ready              byte write handshake
//   wr_addr, wr_data               byte address and value
//   done                           one-cycle pulse at the end of each request
//   err_range, long_form,          status of the most recent request, updated in CALC
//   page_crossed, offset
module branch_encoder #(
   parameter bit         LONG_FORM_EN = 1'b1,
   parameter logic [7:0] JMP_OPCODE   = 8'h4C
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_cond,
   input  logic [15:0] req_pc,
   input  logic [15:0] req_target,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        done,
   output logic        err_range,
   output logic        long_form,
   output logic        page_crossed,
   output logic [7:0]  offset
);

   typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cond_q;
   logic [15:0] pc_q;
   logic [15:0] target_q;
   logic [2:0]  idx;

   logic [15:0] next_pc;
   logic [15:0] diff;
   logic        in_range;
   logic [7:0]  opc;
   logic [2:0]  last_idx;
   logic        wr_fire;

   // Relative branches count from the byte after the 2-byte instruction.
   assign next_pc  = pc_q + 16'd2;
   assign diff     = target_q - next_pc;
   // Reachable when the upper bits are a pure sign extension of bit 7.
   assign in_range = (diff[15:7] == 9'h000) || (diff[15:7] == 9'h1FF);
   assign opc      = {cond_q, 5'b10000};
   assign last_idx = long_form ? 3'd4 : 3'd1;
   assign wr_fire  = (state == EMIT) && wr_ready;

   // State register plus the datapath registers that follow it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cond_q       <= 3'd0;
         pc_q         <= 16'd0;
         target_q     <= 16'd0;
         idx          <= 3'd0;
         offset       <= 8'd0;
         page_crossed <= 1'b0;
         long_form    <= 1'b0;
         err_range    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req_valid) begin
            cond_q   <= req_cond;
            pc_q     <= req_pc;
            target_q <= req_target;
         end
         if (state == CALC) begin
            offset       <= diff[7:0];
            page_crossed <= in_range && (next_pc[15:8] != target_q[15:8]);
            long_form    <= !in_range && LONG_FORM_EN;
            err_range    <= !in_range && !LONG_FORM_EN;
            idx          <= 3'd0;
         end else if (wr_fire) begin
            idx <= idx + 3'd1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = CALC;
         CALC: state_nxt = (!in_range && !LONG_FORM_EN) ? DONE : EMIT;
         EMIT: if (wr_fire && idx == last_idx) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs; address and data are zero outside EMIT and stay put during a stall
   // because idx only moves on a handshake.
   always_comb begin
      req_ready = (state == IDLE);
      done      = (state == DONE);
      wr_valid  = (state == EMIT);
      wr_addr   = 16'd0;
      wr_data   = 8'd0;
      if (state == EMIT) begin
         wr_addr = pc_q + {13'd0, idx};
         if (long_form) begin
            case (idx)
               3'd0:    wr_data = opc ^ 8'h20;   // opposite condition skips the JMP
               3'd1:    wr_data = 8'h03;
               3'd2:    wr_data = JMP_OPCODE;
               3'd3:    wr_data = target_q[7:0];
               3'd4:    wr_data = target_q[15:8];
               default: wr_data = 8'd0;
            endcase
         end else begin
            case (idx)
               3'd0:    wr_data = opc;
               3'd1:    wr_data = offset;
               default: wr_data = 8'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_branch_encoder.sv
// tb/tb_branch_encoder.sv - randomized self-checking bench for branch_encoder
module tb_branch_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [2:0]  req_cond;
   logic [15:0] req_pc;
   logic [15:0] req_target;
   logic        wr_ready;

   logic        ready_a, wv_a, done_a, err_a, long_a, pg_a;
   logic [15:0] wa_a;
   logic [7:0]  wd_a, off_a;
   logic        ready_b, wv_b, done_b, err_b, long_b, pg_b;
   logic [15:0] wa_b;
   logic [7:0]  wd_b, off_b;

   always #5 clk = ~clk;

   branch_encoder #(.LONG_FORM_EN(1'b1), .JMP_OPCODE(8'h4C)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
      .req_cond(req_cond), .req_pc(req_pc), .req_target(req_target),
      .wr_valid(wv_a), .wr_ready(wr_ready), .wr_addr(wa_a), .wr_data(wd_a),
      .done(done_a), .err_range(err_a), .long_form(long_a),
      .page_crossed(pg_a), .offset(off_a));

   branch_encoder #(.LONG_FORM_EN(1'b0), .JMP_OPCODE(8'h4C)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
      .req_cond(req_cond), .req_pc(req_pc), .req_target(req_target),
      .wr_valid(wv_b), .wr_ready(wr_ready), .wr_addr(wa_b), .wr_data(wd_b),
      .done(done_b), .err_range(err_b), .long_form(long_b),
      .page_crossed(pg_b), .offset(off_b));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: 6502 branch opcode table and signed-distance arithmetic
   logic [7:0]  op_tab [8] = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0};
   logic [23:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
   bit          e_in;
   bit          e_pg;
   logic [7:0]  e_off;

   function automatic void model(input logic [2:0] c, input logic [15:0] pc, input logic [15:0] tgt);
      int d;
      int nxt;
      d = int'(tgt) - int'(pc) - 2;
      if (d < -32768) d += 65536;
      if (d > 32767)  d -= 65536;
      nxt   = (int'(pc) + 2) % 65536;
      e_in  = (d >= -128) && (d <= 127);
      e_off = 8'(d & 255);
      e_pg  = e_in && ((nxt / 256) != (int'(tgt) / 256));
      exp_a.delete();
      exp_b.delete();
      if (e_in) begin
         exp_a.push_back({pc, op_tab[c]});
         exp_a.push_back({16'(pc + 16'd1), e_off});
         exp_b = exp_a;
      end else begin
         exp_a.push_back({pc, op_tab[c ^ 3'd1]});
         exp_a.push_back({16'(pc + 16'd1), 8'h03});
         exp_a.push_back({16'(pc + 16'd2), 8'h4C});
         exp_a.push_back({16'(pc + 16'd3), tgt[7:0]});
         exp_a.push_back({16'(pc + 16'd4), tgt[15:8]});
      end
   endfunction

   task automatic do_req(input logic [2:0] c, input logic [15:0] pc, input logic [15:0] tgt,
                         input int stall_pct);
      int  nd_a, nd_b, cyc, tail;
      bit  prev_done_a, held;
      logic [31:0] held_val;
      model(c, pc, tgt);
      got_a.delete();
      got_b.delete();
      nd_a = 0; nd_b = 0; cyc = 0; tail = 0;
      prev_done_a = 0; held = 0; held_val = '0;
      @(negedge clk);
      check("req_ready_idle", {31'd0, ready_a}, 32'd1);
      req_cond = c; req_pc = pc; req_target = tgt; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_busy", {31'd0, ready_a}, 32'd0);
      while (tail < 3 && cyc < 80) begin
         wr_ready = ($urandom_range(99) >= stall_pct);
         #1;
         if (held) begin
            check("stall_hold_valid", {31'd0, wv_a}, 32'd1);
            check("stall_hold_addr_data", {8'd0, wa_a, wd_a}, held_val);
         end
         held = wv_a && !wr_ready;
         held_val = {8'd0, wa_a, wd_a};
         if (wv_a && wr_ready) got_a.push_back({wa_a, wd_a});
         if (wv_b && wr_ready) got_b.push_back({wa_b, wd_b});
         if (prev_done_a) check("ready_after_done", {31'd0, ready_a}, 32'd1);
         prev_done_a = done_a;
         if (done_a) begin
            nd_a++;
            check("a_err_range", {31'd0, err_a}, 32'd0);
            check("a_long_form", {31'd0, long_a}, {31'd0, !e_in});
            check("a_page_crossed", {31'd0, pg_a}, {31'd0, e_pg});
            check("a_offset", {24'd0, off_a}, {24'd0, e_off});
         end
         if (done_b) begin
            nd_b++;
            check("b_err_range", {31'd0, err_b}, {31'd0, !e_in});
            check("b_long_form", {31'd0, long_b}, 32'd0);
            check("b_offset", {24'd0, off_b}, {24'd0, e_off});
         end
         if (nd_a > 0 && nd_b > 0) tail++;
         cyc++;
         @(negedge clk);
      end
      wr_ready = 1'b1;
      check("timeout", {31'd0, (cyc >= 80)}, 32'd0);
      check("a_done_pulses", nd_a, 1);
      check("b_done_pulses", nd_b, 1);
      check("a_byte_count", got_a.size(), exp_a.size());
      check("b_byte_count", got_b.size(), exp_b.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
         check($sformatf("a_byte%0d pc=%h tgt=%h", i, pc, tgt), {8'd0, got_a[i]}, {8'd0, exp_a[i]});
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
         check($sformatf("b_byte%0d", i), {8'd0, got_b[i]}, {8'd0, exp_b[i]});
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_cond = 3'd0; req_pc = 16'd0;
      req_target = 16'd0; wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, ready_a}, 32'd1);
      check("rst_wr_valid", {31'd0, wv_a}, 32'd0);
      check("rst_wr_addr", {16'd0, wa_a}, 32'd0);
      check("rst_wr_data", {24'd0, wd_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
      check("rst_status", {28'd0, err_a, long_a, pg_a, err_b}, 32'd0);
      check("rst_offset", {24'd0, off_a}, 32'd0);
      rst_n = 1'b1;

      do_req(3'd7, 16'h0200, 16'h0210, 0);
      do_req(3'd6, 16'h0210, 16'h0200, 0);
      do_req(3'd4, 16'h02F0, 16'h0300, 0);
      do_req(3'd0, 16'h1000, 16'h1081, 0);
      do_req(3'd0, 16'h1000, 16'h0F82, 0);
      do_req(3'd0, 16'h1000, 16'h1082, 0);
      do_req(3'd3, 16'h1000, 16'h2000, 0);
      do_req(3'd4, 16'hFFFE, 16'h0005, 0);
      do_req(3'd2, 16'hFFFF, 16'h8000, 0);
      do_req(3'd7, 16'h0200, 16'h0210, 60);

      // Reset in the middle of EMIT
      @(negedge clk);
      wr_ready = 1'b0;
      req_cond = 3'd5; req_pc = 16'h4000; req_target = 16'h4010; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_wr_valid", {31'd0, wv_a}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_wr_valid", {31'd0, wv_a}, 32'd0);
      check("midrst_req_ready", {31'd0, ready_a}, 32'd1);
      check("midrst_done", {31'd0, done_a}, 32'd0);
      check("midrst_wr_addr", {16'd0, wa_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("postrst_quiet", {30'd0, done_a, wv_a}, 32'd0);
      end

      for (int n = 0; n < 150; n++) begin
         logic [15:0] p, t;
         p = 16'($urandom());
         if ($urandom_range(2) != 0) t = p + 16'($urandom_range(300)) - 16'd148;
         else                        t = 16'($urandom());
         do_req(3'($urandom_range(7)), p, t, $urandom_range(60));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
